lfsr8_chk: RTL and testbench

LFSR8_CHK -- requirements
Module: lfsr8_chk

---
 rtl/lfsr8_chk.sv | 134 +++++++++++++
 tb/tb_lfsr8_chk.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/lfsr8_chk.sv
// Checker for the receive side of an lfsr8_e pattern link (x^8+x^6+x^5+x^4+1).
// It locks onto the incoming stream and then runs a free-running expected sequence, counting mismatches.
module lfsr8_chk (
    input  logic        clk,
    input  logic        rst,
    input  logic        enb,
    input  logic [7:0]  din,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        err,
    output logic [15:0] err_cnt,
    output logic [15:0] chk_cnt
);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t      state;
    state_t      state_nxt;

    logic [7:0]  prev;
    logic        have_prev;
    logic [1:0]  mcnt;
    logic [7:0]  exp;
    logic [1:0]  miss_cnt;

    logic        search_hit;
    logic        track_hit;
    logic        lock_now;
    logic        lose_now;

    logic        locked_nxt;
    logic        err_nxt;
    logic [15:0] err_cnt_nxt;
    logic [15:0] chk_cnt_nxt;

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    assign search_hit = have_prev && (din != 8'h00) && (din == lfsr_next(prev));
    assign track_hit  = (din == exp);
    assign lock_now   = enb && (state == SEARCH) && search_hit && (mcnt == 2'd2);
    assign lose_now   = enb && (state == LOCKED) && !track_hit && (miss_cnt == 2'd3);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: three straight matches acquire, four straight misses drop lock
    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH:  if (lock_now) state_nxt = LOCKED;
            LOCKED:  if (lose_now) state_nxt = SEARCH;
            default: state_nxt = SEARCH;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        locked_nxt  = (state_nxt == LOCKED);
        err_nxt     = 1'b0;
        err_cnt_nxt = err_cnt;
        chk_cnt_nxt = chk_cnt;
        if (enb && (state == LOCKED)) begin
            if (chk_cnt != 16'hFFFF) chk_cnt_nxt = chk_cnt + 16'd1;
            if (!track_hit) begin
                err_nxt = 1'b1;
                if (err_cnt != 16'hFFFF) err_cnt_nxt = err_cnt + 16'd1;
            end
        end
        if (clr_cnt) begin
            err_cnt_nxt = 16'h0000;
            chk_cnt_nxt = 16'h0000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked  <= 1'b0;
            err     <= 1'b0;
            err_cnt <= 16'h0000;
            chk_cnt <= 16'h0000;
        end else begin
            locked  <= locked_nxt;
            err     <= err_nxt;
            err_cnt <= err_cnt_nxt;
            chk_cnt <= chk_cnt_nxt;
        end
    end

    // Acquisition and flywheel registers; exp is never reloaded from din while locked
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev      <= 8'h00;
            have_prev <= 1'b0;
            mcnt      <= 2'd0;
            exp       <= 8'h00;
            miss_cnt  <= 2'd0;
        end else if (enb) begin
            if (state == SEARCH) begin
                prev      <= din;
                have_prev <= 1'b1;
                if (lock_now) begin
                    mcnt     <= 2'd0;
                    exp      <= lfsr_next(din);
                    miss_cnt <= 2'd0;
                end else if (search_hit) begin
                    mcnt <= mcnt + 2'd1;
                end else begin
                    mcnt <= 2'd0;
                end
            end else begin
                exp <= lfsr_next(exp);
                if (track_hit) begin
                    miss_cnt <= 2'd0;
                end else if (lose_now) begin
                    miss_cnt  <= 2'd0;
                    mcnt      <= 2'd0;
                    have_prev <= 1'b1;
                    prev      <= din;
                end else begin
                    miss_cnt <= miss_cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr8_chk.sv
// Directed bench for lfsr8_chk: acquire, track, single error, lock loss, gaps, clear, reset and saturation.
// Expected values are hand-derived from the sequence 01,02,04,08,11,23,47,8E,1C,38,71,E2,C4,89,12.
module tb_lfsr8_chk;

    logic        clk;
    logic        rst;
    logic        enb;
    logic [7:0]  din;
    logic        clr_cnt;
    logic        locked;
    logic        err;
    logic [15:0] err_cnt;
    logic [15:0] chk_cnt;

    int checks;
    int errors;

    lfsr8_chk dut (
        .clk     (clk),
        .rst     (rst),
        .enb     (enb),
        .din     (din),
        .clr_cnt (clr_cnt),
        .locked  (locked),
        .err     (err),
        .err_cnt (err_cnt),
        .chk_cnt (chk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge, then settle just past the next rising edge
    task automatic applyStimulus(input logic e, input logic [7:0] d, input logic c);
        @(negedge clk);
        enb     = e;
        din     = d;
        clr_cnt = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic expLocked, input logic expErr,
                               input logic [15:0] expErrCnt, input logic [15:0] expChkCnt);
        checks++;
        assert (locked === expLocked) else begin
            errors++;
            $error("FAIL %s.locked observed=%0b expected=%0b", tag, locked, expLocked);
        end
        checks++;
        assert (err === expErr) else begin
            errors++;
            $error("FAIL %s.err observed=%0b expected=%0b", tag, err, expErr);
        end
        checks++;
        assert (err_cnt === expErrCnt) else begin
            errors++;
            $error("FAIL %s.err_cnt observed=%h expected=%h", tag, err_cnt, expErrCnt);
        end
        checks++;
        assert (chk_cnt === expChkCnt) else begin
            errors++;
            $error("FAIL %s.chk_cnt observed=%h expected=%h", tag, chk_cnt, expChkCnt);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        enb     = 1'b0;
        din     = 8'h00;
        clr_cnt = 1'b0;
        #12;
        checkOutput("reset", 1'b0, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Acquire on 01,02,04,08
        applyStimulus(1'b1, 8'h01, 1'b0); checkOutput("acq01", 1'b0, 1'b0, 16'd0, 16'd0);
        applyStimulus(1'b1, 8'h02, 1'b0); checkOutput("acq02", 1'b0, 1'b0, 16'd0, 16'd0);
        applyStimulus(1'b1, 8'h04, 1'b0); checkOutput("acq04", 1'b0, 1'b0, 16'd0, 16'd0);
        applyStimulus(1'b1, 8'h08, 1'b0); checkOutput("acq08", 1'b1, 1'b0, 16'd0, 16'd0);

        // Track
        applyStimulus(1'b1, 8'h11, 1'b0); checkOutput("trk11", 1'b1, 1'b0, 16'd0, 16'd1);
        applyStimulus(1'b1, 8'h23, 1'b0); checkOutput("trk23", 1'b1, 1'b0, 16'd0, 16'd2);
        applyStimulus(1'b1, 8'h47, 1'b0); checkOutput("trk47", 1'b1, 1'b0, 16'd0, 16'd3);
        applyStimulus(1'b1, 8'h8E, 1'b0); checkOutput("trk8E", 1'b1, 1'b0, 16'd0, 16'd4);

        // Single error in place of 1C, then the flywheel continues
        applyStimulus(1'b1, 8'hFF, 1'b0); checkOutput("sglFF", 1'b1, 1'b1, 16'd1, 16'd5);
        applyStimulus(1'b1, 8'h38, 1'b0); checkOutput("sgl38", 1'b1, 1'b0, 16'd1, 16'd6);
        applyStimulus(1'b1, 8'h71, 1'b0); checkOutput("sgl71", 1'b1, 1'b0, 16'd1, 16'd7);

        // Four zeros drop lock on the fourth
        applyStimulus(1'b1, 8'h00, 1'b0); checkOutput("loss1", 1'b1, 1'b1, 16'd2, 16'd8);
        applyStimulus(1'b1, 8'h00, 1'b0); checkOutput("loss2", 1'b1, 1'b1, 16'd3, 16'd9);
        applyStimulus(1'b1, 8'h00, 1'b0); checkOutput("loss3", 1'b1, 1'b1, 16'd4, 16'd10);
        applyStimulus(1'b1, 8'h00, 1'b0); checkOutput("loss4", 1'b0, 1'b1, 16'd5, 16'd11);

        // Reacquire; counters persist
        applyStimulus(1'b1, 8'h01, 1'b0); checkOutput("racq01", 1'b0, 1'b0, 16'd5, 16'd11);
        applyStimulus(1'b1, 8'h02, 1'b0); checkOutput("racq02", 1'b0, 1'b0, 16'd5, 16'd11);
        applyStimulus(1'b1, 8'h04, 1'b0); checkOutput("racq04", 1'b0, 1'b0, 16'd5, 16'd11);
        applyStimulus(1'b1, 8'h08, 1'b0); checkOutput("racq08", 1'b1, 1'b0, 16'd5, 16'd11);

        // Clear on the same edge as a mismatch (expected 11)
        applyStimulus(1'b1, 8'h55, 1'b1); checkOutput("clrmis", 1'b1, 1'b1, 16'd0, 16'd0);
        applyStimulus(1'b1, 8'h23, 1'b0); checkOutput("clr23", 1'b1, 1'b0, 16'd0, 16'd1);

        // enb=0 holds everything and keeps err low
        applyStimulus(1'b0, 8'hA5, 1'b0); checkOutput("hold", 1'b1, 1'b0, 16'd0, 16'd1);

        // Mismatch (expected 47), then asynchronous reset mid-lock
        applyStimulus(1'b1, 8'h00, 1'b0); checkOutput("prerst", 1'b1, 1'b1, 16'd1, 16'd2);
        #2;
        enb = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("asyncrst", 1'b0, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Acquire with enb toggling every cycle
        applyStimulus(1'b1, 8'h01, 1'b0); checkOutput("gap01", 1'b0, 1'b0, 16'd0, 16'd0);
        applyStimulus(1'b0, 8'hAA, 1'b0);
        applyStimulus(1'b1, 8'h02, 1'b0); checkOutput("gap02", 1'b0, 1'b0, 16'd0, 16'd0);
        applyStimulus(1'b0, 8'hAA, 1'b0);
        applyStimulus(1'b1, 8'h04, 1'b0);
        applyStimulus(1'b0, 8'hAA, 1'b0); checkOutput("gapidle", 1'b0, 1'b0, 16'd0, 16'd0);
        applyStimulus(1'b1, 8'h08, 1'b0); checkOutput("gap08", 1'b1, 1'b0, 16'd0, 16'd0);

        // Saturation: preload err_cnt, then a mismatch (expected 11) must leave it at FFFF
        force dut.err_cnt = 16'hFFFF;
        #1;
        release dut.err_cnt;
        applyStimulus(1'b1, 8'h00, 1'b0); checkOutput("satmis", 1'b1, 1'b1, 16'hFFFF, 16'd1);
        applyStimulus(1'b1, 8'h23, 1'b0); checkOutput("sat23", 1'b1, 1'b0, 16'hFFFF, 16'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
